mem_bus_decoder: RTL

//  Parametrised N-slave memory-bus decoder between the CPU valid/ready port and
//  its targets (RAM, peripherals, external memory). Decodes each request by

---
 rtl/mem_bus_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_decoder.sv
// Memory-bus decoder: routes one CPU valid/ready request to one of N slaves.
// Registers the response and turns unmapped or stalled accesses into bus errors.
`timescale 1ns/1ps
module mem_bus_decoder #(
   parameter int NSLAVES = 4,
   parameter logic [NSLAVES*32-1:0] SLAVE_BASE =
      {32'h01000000, 32'h00020000, 32'h00010000, 32'h00000000},
   parameter logic [NSLAVES*32-1:0] SLAVE_MASK =
      {32'hFF000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000},
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m_valid,
   output logic                  m_ready,
   input  logic [31:0]           m_addr,
   input  logic [31:0]           m_wdata,
   input  logic [3:0]            m_wstrb,
   output logic [31:0]           m_rdata,
   output logic                  m_error,
   output logic [NSLAVES-1:0]    s_valid,
   input  logic [NSLAVES-1:0]    s_ready,
   output logic [31:0]           s_addr,
   output logic [31:0]           s_wdata,
   output logic [3:0]            s_wstrb,
   input  logic [NSLAVES*32-1:0] s_rdata,
   output logic [15:0]           err_count
);

   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e              state_q, state_d;
   logic [SW-1:0]       sel_q, sel_d;
   logic [15:0]         timer_q, timer_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [NSLAVES-1:0]  sv_q, sv_d;
   logic [15:0]         cnt_q, cnt_d;

   logic                hit;
   logic [SW-1:0]       hit_idx;
   logic                rdy_sel;
   logic [31:0]         rd_sel;
   logic                inc_err;

   // Descending scan so the lowest matching index has the final say.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   always_comb begin
      rdy_sel = 1'b0;
      rd_sel  = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         if (sel_q == SW'(i)) begin
            rdy_sel = s_ready[i];
            rd_sel  = s_rdata[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      timer_d = timer_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      sv_d    = sv_q;
      cnt_d   = cnt_q;
      inc_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (m_valid) begin
               addr_d  = m_addr;
               wdata_d = m_wdata;
               wstrb_d = m_wstrb;
               timer_d = '0;
               if (hit) begin
                  sel_d   = hit_idx;
                  state_d = BUSY;
                  for (int i = 0; i < NSLAVES; i++) begin
                     sv_d[i] = (hit_idx == SW'(i));
                  end
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  inc_err = 1'b1;
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            // Ready beats a timeout that lands on the same edge.
            if (rdy_sel) begin
               rdata_d = (wstrb_q != 4'b0) ? 32'h0 : rd_sel;
               err_d   = 1'b0;
               sv_d    = '0;
               state_d = RESP;
            end else if (timer_q == 16'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               inc_err = 1'b1;
               sv_d    = '0;
               state_d = RESP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         RESP: begin
            sv_d    = '0;
            timer_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (inc_err && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         timer_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         sv_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         timer_q <= timer_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         sv_q    <= sv_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_ready   = (state_q == RESP);
   assign m_rdata   = rdata_q;
   assign m_error   = err_q;
   assign s_valid   = sv_q;
   assign s_addr    = addr_q;
   assign s_wdata   = wdata_q;
   assign s_wstrb   = wstrb_q;
   assign err_count = cnt_q;

endmodule
